retire_free_list: RTL
=====================

RETIRE_FREE_LIST -- requirements
Module: retire_free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, total physical registers; P0 hardwired zero, never allocated or freed.
REQ-002 SHALL have parameter NUM_AREGS, default 32, architectural registers; P0..P(NUM_AREGS-1) hold initial mappings.
REQ-003 SHALL have parameter PREG_W, default 6, physical register index width (log2 NUM_PREGS).
REQ-004 SHALL have ports: i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have i_retire_valid  input  2  per-lane retire-row valid from the completion/ROB stage, lane 0 oldest.
REQ-007 SHALL have i_retire_regwrite  input  2  per-lane RegWrite of the retired row.
REQ-008 SHALL have i_retire_old_preg  input  2xPREG_W  per-lane OldPRegAddrDst to return to the free list.
REQ-009 SHALL have i_alloc_req  input  2  rename-stage request mask; lane 1 only with lane 0 set.
REQ-010 SHALL have o_free_preg  output  2xPREG_W  head and head+1 free-list entries offered to rename.
REQ-011 SHALL have o_alloc_ok  output  1  all requested registers available this cycle.
REQ-012 SHALL have o_free_count  output  PREG_W+1  registered number of free entries.
REQ-013 SHALL have o_retired_count  output  32  registered count of retired instructions, wraps modulo 2^32.
REQ-014 SHALL have o_overflow  output  1  sticky error: push attempted into a full list.

Function
REQ-015 Free list SHALL be a circular FIFO of depth NUM_PREGS-NUM_AREGS with head, tail pointers and a count register.
REQ-016 Pop SHALL be all-or-nothing: o_alloc_ok = (popcount(i_alloc_req) <= o_free_count); when high, head advances by popcount(i_alloc_req) at the edge; when low, no pop.
REQ-017 o_alloc_ok SHALL be 1 when i_alloc_req = 0.
REQ-018 o_free_preg SHALL be combinational reads of entries at head and head+1 (mod depth); values are don't-care beyond o_free_count.
REQ-019 A retire lane SHALL push its old preg iff valid, regwrite, and old preg != 0.
REQ-020 Two pushes in one cycle SHALL be written lane 0 at tail, lane 1 at tail+1; a single push from lane 1 only SHALL be written at tail (lanes compacted).
REQ-021 Pointers SHALL wrap from depth-1 to 0; a two-entry push/pop straddling the wrap SHALL use indices depth-1 and 0.
REQ-022 Same-cycle push and pop SHALL be legal; availability is judged on pre-edge count only (no bypass of same-cycle pushes); count_next = count - pops + pushes.
REQ-023 A push that would exceed depth (count - pops + pushes > depth) SHALL drop the excess entry (lane 1 dropped first), set o_overflow, and leave count = depth.
REQ-024 o_retired_count SHALL increment by popcount(i_retire_valid) each cycle, independent of regwrite.
REQ-025 o_overflow SHALL remain set until reset.
REQ-026 Latency: a register pushed at edge N SHALL be allocatable in the cycle following edge N.

Reset
REQ-027 Asserting i_rst SHALL immediately, without clock, set head = 0, tail = 0, count = depth, o_retired_count = 0, o_overflow = 0.
REQ-028 Reset SHALL load entry k with P(NUM_AREGS+k), so o_free_preg = {P32, P33} with default parameters.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight pushes and pops of that cycle; no operation occurs while i_rst is high.

Verification
REQ-030 Reset, then i_alloc_req=2'b11 for 16 cycles -> grants P32..P63 in order, o_free_count=0, then o_alloc_ok=0 with req=2'b01.
REQ-031 Empty list, retire both lanes regwrite with old preg 5 and 9 while requesting 2'b01 -> o_alloc_ok=0 that cycle; next cycle o_free_preg={5,9}, o_free_count=2.
REQ-032 Retire lane 0 old preg 0 with regwrite, lane 1 old preg 7 -> only P7 pushed at tail, o_free_count +1, o_retired_count +2.
REQ-033 Full list (count=32), retire two regwrite rows, no alloc -> o_overflow=1, count stays 32, contents unchanged.
REQ-034 Drive head to 31, pop two -> grants entries at indices 31 and 0; push across tail wrap likewise lands at 31 and 0.
REQ-035 Assert i_rst asynchronously between edges with count=10 -> outputs return to REQ-027/028 values before the next edge.

Source files
------------

// File: rtl/retire_free_list.sv
// Retirement-side physical register free list.
// Circular FIFO of (NUM_PREGS - NUM_AREGS) entries. Up to two old pregs are
// pushed per cycle from retire and up to two are popped per cycle by rename.
// Pops are all-or-nothing and are judged on the pre-edge count only.
module retire_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = 6
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_retire_valid,
    input  logic [1:0]             i_retire_regwrite,
    input  logic [1:0][PREG_W-1:0] i_retire_old_preg,
    input  logic [1:0]             i_alloc_req,
    output logic [1:0][PREG_W-1:0] o_free_preg,
    output logic                   o_alloc_ok,
    output logic [PREG_W:0]        o_free_count,
    output logic [31:0]            o_retired_count,
    output logic                   o_overflow
);

    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PREG_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PREG_W-1:0] mem_q [DEPTH];
    logic [PREG_W-1:0] mem_d [DEPTH];
    logic [31:0]       retired_q, retired_d;
    logic              overflow_q, overflow_d;

    logic [1:0]        n_req, n_pop, n_push_req, n_push, n_ret;
    logic [1:0]        push_vec;
    logic [PREG_W-1:0] push_first;
    logic [CNT_W-1:0]  avail, space;
    logic              alloc_ok;

    // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [1:0] n);
        logic [PTR_W:0] s;
        s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
        if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    // Next-state: pop/push arbitration, compaction, overflow clipping.
    always_comb begin
        n_req      = {1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]};
        alloc_ok   = (CNT_W'(n_req) <= count_q);
        n_pop      = alloc_ok ? n_req : 2'd0;

        for (int i = 0; i < 2; i++)
            push_vec[i] = i_retire_valid[i] & i_retire_regwrite[i] &
                          (i_retire_old_preg[i] != '0);
        n_push_req = {1'b0, push_vec[0]} + {1'b0, push_vec[1]};
        // Lane 1 slides into the tail slot when lane 0 has nothing to push.
        push_first = push_vec[0] ? i_retire_old_preg[0] : i_retire_old_preg[1];

        avail      = count_q - CNT_W'(n_pop);
        space      = CNT_W'(DEPTH) - avail;
        // Clipping keeps the older push; the second (lane 1) is lost first.
        if (CNT_W'(n_push_req) > space) n_push = space[1:0];
        else                            n_push = n_push_req;
        overflow_d = overflow_q | (CNT_W'(n_push_req) > space);

        mem_d = mem_q;
        if (n_push != 2'd0) mem_d[tail_q] = push_first;
        if (n_push == 2'd2) mem_d[ptr_add(tail_q, 2'd1)] = i_retire_old_preg[1];

        count_d   = avail + CNT_W'(n_push);
        head_d    = ptr_add(head_q, n_pop);
        tail_d    = ptr_add(tail_q, n_push);
        n_ret     = {1'b0, i_retire_valid[0]} + {1'b0, i_retire_valid[1]};
        retired_d = retired_q + 32'(n_ret);
    end

    // State registers; reset refills the list with P(NUM_AREGS)..P(NUM_PREGS-1).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CNT_W'(DEPTH);
            retired_q  <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                mem_q[k] <= PREG_W'(NUM_AREGS + k);
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            retired_q  <= retired_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign o_free_preg[0]  = mem_q[head_q];
    assign o_free_preg[1]  = mem_q[ptr_add(head_q, 2'd1)];
    assign o_alloc_ok      = alloc_ok;
    assign o_free_count    = count_q;
    assign o_retired_count = retired_q;
    assign o_overflow      = overflow_q;

endmodule
